multi_divider: RTL and testbench

Parametrised multi-channel successor to the single-channel clock divider. It provides CHANNELS independent counters, each with its own goal, periodic or one-shot mode, start/stop/hold control, and a registered one-cycle alarm pulse. It sits between the system clock and the scan, debounce and display-multiplex logic, replacing several separate divider instances.

---
 rtl/multi_divider.sv | 128 ++++++++++++
 tb/tb_multi_divider.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multi_divider.sv
// Multi-channel programmable clock divider: per-channel periodic/one-shot counters with registered alarm pulses.
// Optional square-wave outputs are enabled by defining MULTI_DIVIDER_SQUARE_EN.
module multi_divider #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       hold,
    input  logic [CHANNELS-1:0]       oneshot,
    input  logic [CHANNELS*WIDTH-1:0] goal,
`ifdef MULTI_DIVIDER_SQUARE_EN
    output logic [CHANNELS-1:0]       square,
`endif
    output logic [CHANNELS-1:0]       alarm,
    output logic [CHANNELS-1:0]       running,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS*WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q [CHANNELS];
    state_e               state_d [CHANNELS];
    logic   [WIDTH-1:0]   count_q [CHANNELS];
    logic   [WIDTH-1:0]   count_d [CHANNELS];
    logic   [WIDTH-1:0]   goal_q  [CHANNELS];
    logic   [WIDTH-1:0]   goal_d  [CHANNELS];
    logic [CHANNELS-1:0]  mode_q, mode_d;
    logic [CHANNELS-1:0]  alarm_q, alarm_d;
`ifdef MULTI_DIVIDER_SQUARE_EN
    logic [CHANNELS-1:0]  square_q, square_d;
`endif

    // Priority per channel: stop > start > hold > count (reset handled in the register block).
    always_comb begin
        mode_d  = mode_q;
        alarm_d = '0;
`ifdef MULTI_DIVIDER_SQUARE_EN
        square_d = square_q;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            goal_d[i]  = goal_q[i];
            if (stop[i]) begin
                state_d[i] = IDLE;
                count_d[i] = '0;
`ifdef MULTI_DIVIDER_SQUARE_EN
                square_d[i] = 1'b0;
`endif
            end else if (start[i]) begin
                state_d[i] = RUN;
                count_d[i] = '0;
                goal_d[i]  = goal[i*WIDTH +: WIDTH];
                mode_d[i]  = oneshot[i];
`ifdef MULTI_DIVIDER_SQUARE_EN
                square_d[i] = 1'b0;
`endif
            end else if (state_q[i] == RUN && !hold[i]) begin
                if (count_q[i] == goal_q[i]) begin
                    count_d[i] = '0;
                    alarm_d[i] = 1'b1;
`ifdef MULTI_DIVIDER_SQUARE_EN
                    square_d[i] = ~square_q[i];
`endif
                    if (mode_q[i]) begin
                        state_d[i] = DONE;
                    end else begin
                        // Goal changes only take effect at period boundaries.
                        goal_d[i] = goal[i*WIDTH +: WIDTH];
                    end
                end else begin
                    count_d[i] = count_q[i] + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= '0;
            alarm_q <= '0;
`ifdef MULTI_DIVIDER_SQUARE_EN
            square_q <= '0;
`endif
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= IDLE;
                count_q[i] <= '0;
                goal_q[i]  <= '0;
            end
        end else begin
            mode_q  <= mode_d;
            alarm_q <= alarm_d;
`ifdef MULTI_DIVIDER_SQUARE_EN
            square_q <= square_d;
`endif
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
                goal_q[i]  <= goal_d[i];
            end
        end
    end

    always_comb begin
        count   = '0;
        running = '0;
        done    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            count[i*WIDTH +: WIDTH] = count_q[i];
            running[i]              = (state_q[i] == RUN);
            done[i]                 = (state_q[i] == DONE);
        end
    end

    assign alarm = alarm_q;
`ifdef MULTI_DIVIDER_SQUARE_EN
    assign square = square_q;
`endif

endmodule

// File: tb/tb_multi_divider.sv
// Directed bench for multi_divider (WIDTH=8, CHANNELS=2); square checks only when MULTI_DIVIDER_SQUARE_EN is defined.
module tb_multi_divider;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [CHANNELS-1:0]       start, stop, hold, oneshot;
    logic [CHANNELS*WIDTH-1:0] goal;
    logic [CHANNELS-1:0]       alarm, running, done;
    logic [CHANNELS*WIDTH-1:0] count;
`ifdef MULTI_DIVIDER_SQUARE_EN
    logic [CHANNELS-1:0]       square;
`endif

    int checks   = 0;
    int failures = 0;

    multi_divider #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .hold    (hold),
        .oneshot (oneshot),
        .goal    (goal),
`ifdef MULTI_DIVIDER_SQUARE_EN
        .square  (square),
`endif
        .alarm   (alarm),
        .running (running),
        .done    (done),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int exp_cnt_hold [11] = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 0, 1};

    initial begin
        reset = 1'b0; start = '0; stop = '0; hold = '0; oneshot = '0; goal = '0;
        #2;

        // Reset with random inputs
        start = CHANNELS'($urandom); stop = CHANNELS'($urandom);
        hold = CHANNELS'($urandom); oneshot = CHANNELS'($urandom);
        goal = 16'($urandom);
        reset = 1'b1;
        tick();
        chk("reset_alarm", 32'(alarm), 0);
        chk("reset_running", 32'(running), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_count", 32'(count), 0);
        reset = 1'b0; start = '0; stop = '0; hold = '0; oneshot = '0; goal = '0;
        tick();

        // Periodic ch0, goal 9: alarms after edges 10, 20, 30
        goal[7:0] = 8'd9; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        chk("per_start_running", 32'(running[0]), 1);
        chk("per_start_count", 32'(count[7:0]), 0);
        for (int e = 1; e <= 30; e++) begin
            tick();
            chk($sformatf("per_alarm_e%0d", e), 32'(alarm[0]), 32'((e % 10) == 0));
            chk($sformatf("per_count_e%0d", e), 32'(count[7:0]), 32'(e % 10));
            chk($sformatf("per_running_e%0d", e), 32'(running[0]), 1);
        end
        chk("per_ch1_idle", 32'(running[1]), 0);
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
        chk("per_stop_running", 32'(running[0]), 0);
        chk("per_stop_count", 32'(count[7:0]), 0);

        // One-shot ch1, goal 3: single alarm after edge 4
        goal[15:8] = 8'd3; oneshot[1] = 1'b1; start[1] = 1'b1;
        tick();
        start[1] = 1'b0; oneshot[1] = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            tick();
            chk($sformatf("os_alarm_e%0d", e), 32'(alarm[1]), 32'(e == 4));
            chk($sformatf("os_done_e%0d", e), 32'(done[1]), 32'(e >= 4));
            chk($sformatf("os_running_e%0d", e), 32'(running[1]), 32'(e < 4));
            chk($sformatf("os_count_e%0d", e), 32'(count[15:8]), (e < 4) ? 32'(e) : 0);
        end
        stop[1] = 1'b1;
        tick();
        stop[1] = 1'b0;
        chk("os_stop_done", 32'(done[1]), 0);

        // Hold ch0, goal 5: hold on edges 3..5, alarm moves from edge 6 to 9
        goal[7:0] = 8'd5; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            hold[0] = (e >= 3 && e <= 5);
            tick();
            chk($sformatf("hold_alarm_e%0d", e), 32'(alarm[0]), 32'(e == 9));
            chk($sformatf("hold_count_e%0d", e), 32'(count[7:0]), 32'(exp_cnt_hold[e]));
        end
        hold[0] = 1'b0;

        // goal 0 periodic: alarm every cycle
        goal[7:0] = 8'd0; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        chk("g0_first_alarm", 32'(alarm[0]), 0);
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk($sformatf("g0_alarm_e%0d", e), 32'(alarm[0]), 1);
            chk($sformatf("g0_count_e%0d", e), 32'(count[7:0]), 0);
        end

        // Goal change 9 -> 4 mid-period: alarms after edges 10 and 15
        goal[7:0] = 8'd9; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            if (e == 3) goal[7:0] = 8'd4;
            tick();
            chk($sformatf("gchg_alarm_e%0d", e), 32'(alarm[0]), 32'(e == 10 || e == 15));
        end

        // stop and start together -> IDLE
        stop[0] = 1'b1; start[0] = 1'b1;
        tick();
        stop[0] = 1'b0; start[0] = 1'b0;
        chk("ss_running", 32'(running[0]), 0);
        chk("ss_done", 32'(done[0]), 0);
        chk("ss_count", 32'(count[7:0]), 0);
        tick();
        chk("ss_count_stays", 32'(count[7:0]), 0);

        // Reset at count 7; ch1 (goal 7) would alarm on the reset edge
        goal = {8'd7, 8'd9}; start = 2'b11;
        tick();
        start = '0;
        repeat (7) tick();
        chk("rst7_count_pre", 32'(count), 32'({8'd7, 8'd7}));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst7_alarm", 32'(alarm), 0);
        chk("rst7_running", 32'(running), 0);
        chk("rst7_done", 32'(done), 0);
        chk("rst7_count", 32'(count), 0);

`ifdef MULTI_DIVIDER_SQUARE_EN
        // Square wave ch0, goal 4: toggles after edges 5, 10, 15
        chk("sq_reset", 32'(square), 0);
        goal[7:0] = 8'd4; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            chk($sformatf("sq_e%0d", e), 32'(square[0]),
                32'((e >= 5 && e < 10) || e >= 15));
        end
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
        chk("sq_stop", 32'(square[0]), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
